// File: rtl/seq_multiplier.sv
// Iterative 24x24 -> 48-bit shift-add multiplier: one partial product per clock,
// sign handled by magnitude multiply plus a final two's-complement fix-up.
module seq_multiplier #(
    parameter int WIDTH = 24
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      mcand;
    logic [2*WIDTH-1:0]    mplier;
    logic [2*WIDTH-1:0]    acc;
    logic [2*WIDTH-1:0]    acc_next;
    logic [CW-1:0]         count;
    logic                  neg;
    logic                  accept;
    logic                  last;
    logic [WIDTH-1:0]      mag_a, mag_b;

    assign accept   = Start && (state == IDLE || state == DONE);
    assign last     = (count == CW'(WIDTH - 1));
    assign mag_a    = (Signed && OpA[WIDTH-1]) ? -OpA : OpA;
    assign mag_b    = (Signed && OpB[WIDTH-1]) ? -OpB : OpB;
    // Include the final partial product so Product is complete on the last BUSY edge.
    assign acc_next = acc + (mcand[0] ? mplier : '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: if (Start) state_next = BUSY;
            BUSY: begin
                Busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = Start ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            neg     <= 1'b0;
            Product <= '0;
        end else if (accept) begin
            mcand  <= mag_a;
            mplier <= {{WIDTH{1'b0}}, mag_b};
            neg    <= Signed & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand >> 1;
            mplier <= mplier << 1;
            count  <= count + CW'(1);
            if (last) Product <= neg ? -acc_next : acc_next;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected product and Done
// cycle; a negedge monitor pops on Done and checks Product stability otherwise.
module tb_seq_multiplier;

    localparam int W = 24;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;

    logic               Clock, Reset, Start, Signed;
    logic [W-1:0]       OpA, OpB;
    logic               Busy, Done;
    logic [2*W-1:0]     Product;

    exp_t               sb[$];
    int                 cyc;
    int                 checks;
    int                 failures;
    logic [2*W-1:0]     held;

    seq_multiplier #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
        .OpA(OpA), .OpB(OpB), .Busy(Busy), .Done(Done), .Product(Product)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: result and latency on Done, Product hold in every other cycle.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (Done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 48'd1, 48'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", Product, e.p);
                    check("done_cycle", 48'(cyc), 48'(e.cyc));
                    check("busy_low_at_done", 48'(Busy), 48'd0);
                    held = e.p;
                end
            end else begin
                check("product_stable", Product, held);
            end
        end
    end

    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
        exp_t e;
        @(negedge Clock);
        Start = 1'b1; Signed = s; OpA = a; OpB = b;
        e.p = exp; e.cyc = cyc + 1 + W;
        sb.push_back(e);
        @(negedge Clock);
        Start = 1'b0;
        OpA = W'($urandom); OpB = W'($urandom); Signed = ~s;
        check("busy_after_accept", 48'(Busy), 48'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge Clock); #1;
        end
        check("drain_timeout", 48'(sb.size()), 48'd0);
    endtask

    initial begin
        int k;
        exp_t e;
        checks = 0; failures = 0; held = '0;
        Reset = 1'b1; Start = 1'b1; Signed = 1'b0; OpA = 24'hFFFFFF; OpB = 24'hFFFFFF;

        // Reset with Start high: nothing accepted.
        repeat (3) @(negedge Clock);
        check("rst_busy", 48'(Busy), 48'd0);
        check("rst_done", 48'(Done), 48'd0);
        check("rst_product", Product, 48'h0);
        Start = 1'b0; Reset = 1'b0;
        @(negedge Clock);
        check("idle_after_rst", 48'(Busy), 48'd0);

        do_op(1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001); drain();
        do_op(1'b1, 24'hFFFFFD, 24'd7,      48'hFFFFFFFFFFEB); drain();
        do_op(1'b1, 24'h800000, 24'h800000, 48'h400000000000); drain();
        do_op(1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001); drain();
        do_op(1'b1, 24'h7FFFFF, 24'h800000, 48'hC00000800000); drain();
        do_op(1'b0, 24'h000000, 24'hABCDEF, 48'h0);            drain();

        // Start re-pulsed mid-BUSY with new operands is ignored.
        do_op(1'b0, 24'd100, 24'd200, 48'h4E20);
        repeat (5) @(negedge Clock);
        Start = 1'b1; OpA = 24'd1; OpB = 24'd1;
        @(negedge Clock);
        Start = 1'b0;
        drain();

        // Start held high through DONE: back-to-back accept.
        @(negedge Clock);
        Start = 1'b1; Signed = 1'b0; OpA = 24'd3; OpB = 24'd4;
        k = cyc + 1;
        e.p = 48'd12; e.cyc = k + W; sb.push_back(e);
        e.p = 48'hFFFFFFFFFFF6; e.cyc = k + W + 1 + W; sb.push_back(e);
        @(negedge Clock);
        Signed = 1'b1; OpA = 24'hFFFFFE; OpB = 24'd5;
        while (cyc < k + W + 1) @(negedge Clock);
        Start = 1'b0;
        drain();

        // Reset after 10 iterations: abort, Product cleared, no Done.
        @(negedge Clock);
        Start = 1'b1; Signed = 1'b0; OpA = 24'd9; OpB = 24'd9;
        k = cyc + 1;
        @(negedge Clock);
        Start = 1'b0;
        while (cyc < k + 10) @(negedge Clock);
        #2 Reset = 1'b1;
        held = '0;
        #1;
        check("abort_busy", 48'(Busy), 48'd0);
        check("abort_done", 48'(Done), 48'd0);
        check("abort_product", Product, 48'h0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (W + 3) @(negedge Clock);
        check("abort_no_restart", 48'(Busy), 48'd0);

        do_op(1'b0, 24'd5, 24'd6, 48'd30); drain();
        // Previous 30 must hold through this BUSY (checked by the monitor).
        do_op(1'b0, 24'h123456, 24'h10, 48'h000001234560); drain();

        repeat (3) @(negedge Clock);
        check("sb_empty", 48'(sb.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
